// File: rtl/axis_signed_divider.sv
// Fully pipelined signed divider: one {quotient, remainder} per clock, fixed latency of DIVIDEND_W+2.
// Pipeline: input register, magnitude register, DIVIDEND_W restoring stages, sign-corrected output register.
module axis_signed_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 24
) (
    input  logic                             aclk,
    input  logic                             rst,
    input  logic                             s_axis_divisor_tvalid,
    output logic                             s_axis_divisor_tready,
    input  logic [DIVISOR_W-1:0]             s_axis_divisor_tdata,
    input  logic                             s_axis_dividend_tvalid,
    output logic                             s_axis_dividend_tready,
    input  logic [DIVIDEND_W-1:0]            s_axis_dividend_tdata,
    output logic                             m_axis_dout_tvalid,
    output logic [DIVIDEND_W+DIVISOR_W-1:0]  m_axis_dout_tdata
);

    localparam int LATENCY = DIVIDEND_W + 2;
    localparam int NS      = DIVIDEND_W;
    localparam int OUT_W   = DIVIDEND_W + DIVISOR_W;

    // Handshake: a pair is taken on a rising edge when both tvalids and tready are high;
    // tready only drops in reset and the output has no tready, so nothing ever stalls.
    logic r_ready;

    logic                  r_in_valid;
    logic [DIVIDEND_W-1:0] r_in_dvd;
    logic [DIVISOR_W-1:0]  r_in_dsr;

    logic                  r_st_valid [0:NS];
    logic [DIVISOR_W-1:0]  r_st_rem   [0:NS];
    logic [DIVIDEND_W-1:0] r_st_qd    [0:NS];
    logic [DIVISOR_W-1:0]  r_st_den   [0:NS-1];
    logic                  r_st_qneg  [0:NS];
    logic                  r_st_rneg  [0:NS];
    logic                  r_st_zero  [0:NS];

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;

    logic                  w_accept;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic [DIVISOR_W:0]    w_shift   [1:NS];
    logic                  w_ge      [1:NS];
    logic [DIVISOR_W-1:0]  w_rem_nxt [1:NS];
    logic [DIVIDEND_W-1:0] w_qd_nxt  [1:NS];
    logic [DIVIDEND_W-1:0] w_quo;
    logic [DIVISOR_W-1:0]  w_rem;

    assign w_accept  = s_axis_dividend_tvalid & s_axis_divisor_tvalid & r_ready;
    assign w_dvd_mag = r_in_dvd[DIVIDEND_W-1] ? -r_in_dvd : r_in_dvd;
    assign w_dsr_mag = r_in_dsr[DIVISOR_W-1]  ? -r_in_dsr : r_in_dsr;

    // qd holds the not-yet-consumed dividend bits on top, quotient bits shift in at the bottom.
    always_comb begin
        for (int s = 1; s <= NS; s++) begin
            w_shift[s]   = {r_st_rem[s-1], r_st_qd[s-1][DIVIDEND_W-1]};
            w_ge[s]      = (w_shift[s] >= {1'b0, r_st_den[s-1]});
            w_rem_nxt[s] = w_ge[s] ? (w_shift[s][DIVISOR_W-1:0] - r_st_den[s-1])
                                   : w_shift[s][DIVISOR_W-1:0];
            w_qd_nxt[s]  = {r_st_qd[s-1][DIVIDEND_W-2:0], w_ge[s]};
        end
    end

    assign w_quo = r_st_qneg[NS] ? -r_st_qd[NS]  : r_st_qd[NS];
    assign w_rem = r_st_rneg[NS] ? -r_st_rem[NS] : r_st_rem[NS];

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_ready     <= 1'b0;
            r_in_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int s = 0; s <= NS; s++) begin
                r_st_valid[s] <= 1'b0;
            end
        end else begin
            r_ready       <= 1'b1;
            r_in_valid    <= w_accept;
            r_st_valid[0] <= r_in_valid;
            for (int s = 1; s <= NS; s++) begin
                r_st_valid[s] <= r_st_valid[s-1];
            end
            r_out_valid <= r_st_valid[NS];
            r_out_data  <= r_st_zero[NS] ? '0 : {w_quo, w_rem};
        end
    end

    // Datapath runs freely; only the valid bits qualify it.
    always_ff @(posedge aclk) begin
        r_in_dvd     <= s_axis_dividend_tdata;
        r_in_dsr     <= s_axis_divisor_tdata;
        r_st_rem[0]  <= '0;
        r_st_qd[0]   <= w_dvd_mag;
        r_st_den[0]  <= w_dsr_mag;
        r_st_qneg[0] <= r_in_dvd[DIVIDEND_W-1] ^ r_in_dsr[DIVISOR_W-1];
        r_st_rneg[0] <= r_in_dvd[DIVIDEND_W-1];
        r_st_zero[0] <= (r_in_dsr == '0);
        for (int s = 1; s <= NS; s++) begin
            r_st_rem[s]  <= w_rem_nxt[s];
            r_st_qd[s]   <= w_qd_nxt[s];
            r_st_qneg[s] <= r_st_qneg[s-1];
            r_st_rneg[s] <= r_st_rneg[s-1];
            r_st_zero[s] <= r_st_zero[s-1];
        end
        for (int s = 1; s < NS; s++) begin
            r_st_den[s] <= r_st_den[s-1];
        end
    end

    assign s_axis_divisor_tready  = r_ready;
    assign s_axis_dividend_tready = r_ready;
    assign m_axis_dout_tvalid     = r_out_valid;
    assign m_axis_dout_tdata      = r_out_data;

    initial assert (LATENCY == NS + 2);

endmodule

// File: tb/tb_axis_signed_divider.sv
// Self-checking bench for axis_signed_divider: directed corner cases, random bursts,
// a one-cycle operand gap and a mid-burst reset, all checked through an expected-result queue.
module tb_axis_signed_divider;

    localparam int LAT = 34;

    logic        aclk;
    logic        rst;
    logic        dsr_tvalid;
    logic        dsr_tready;
    logic [23:0] dsr_tdata;
    logic        dvd_tvalid;
    logic        dvd_tready;
    logic [31:0] dvd_tdata;
    logic        dout_tvalid;
    logic [55:0] dout_tdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [55:0] exp_q[$];
    int          due_q[$];

    axis_signed_divider dut (
        .aclk                   (aclk),
        .rst                    (rst),
        .s_axis_divisor_tvalid  (dsr_tvalid),
        .s_axis_divisor_tready  (dsr_tready),
        .s_axis_divisor_tdata   (dsr_tdata),
        .s_axis_dividend_tvalid (dvd_tvalid),
        .s_axis_dividend_tready (dvd_tready),
        .s_axis_dividend_tdata  (dvd_tdata),
        .m_axis_dout_tvalid     (dout_tvalid),
        .m_axis_dout_tdata      (dout_tdata)
    );

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [55:0] model(input logic [31:0] a, input logic [23:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) return '0;
        q = la / lb;
        r = la % lb;
        return {q[31:0], r[23:0]};
    endfunction

    // driver: present one cycle of stimulus, record the expected result if a pair is taken
    task automatic drive(input logic [31:0] a, input logic [23:0] b, input logic va,
                         input logic vb, input logic [55:0] exp, input bit use_exp);
        dvd_tdata  = a;
        dsr_tdata  = b;
        dvd_tvalid = va;
        dsr_tvalid = vb;
        if (va && vb) begin
            exp_q.push_back(use_exp ? exp : model(a, b));
            due_q.push_back(cyc + LAT + 1);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom, 24'($urandom), 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic send_rand();
        logic [31:0] a;
        logic [23:0] b;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: b = 24'($urandom_range(1, 50));
            1: b = -24'($urandom_range(1, 50));
            2: b = 24'($urandom);
            default: b = 24'($urandom_range(1000, 200000));
        endcase
        drive(a, b, 1'b1, 1'b1, '0, 1'b0);
    endtask

    // scoreboard / monitor
    always @(negedge aclk) begin
        logic exp_v;
        if (!rst) begin
            exp_v = (exp_q.size() > 0) && (due_q[0] == cyc);
            check("tvalid", 64'(dout_tvalid), 64'(exp_v));
            if (dout_tvalid && exp_v) begin
                check("dout", 64'(dout_tdata), 64'(exp_q[0]));
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        dvd_tvalid = 1'b0;
        dsr_tvalid = 1'b0;
        dvd_tdata  = '0;
        dsr_tdata  = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_dvd_tready", 64'(dvd_tready), 64'd0);
        check("rst_dsr_tready", 64'(dsr_tready), 64'd0);
        check("rst_tvalid", 64'(dout_tvalid), 64'd0);
        check("rst_tdata", 64'(dout_tdata), 64'd0);
        rst = 1'b0;
        #1;
        check("rel_tready", 64'(dvd_tready), 64'd0);
        @(posedge aclk);
        #1;
        check("up_dvd_tready", 64'(dvd_tready), 64'd1);
        check("up_dsr_tready", 64'(dsr_tready), 64'd1);

        // directed arithmetic cases
        drive(32'd19_607_800, 24'd100_000, 1'b1, 1'b1, {32'd196, 24'd7_800}, 1'b1);
        idle(40);
        drive(32'd50_000_000, 24'd100_000, 1'b1, 1'b1, {32'd500, 24'd0}, 1'b1);
        drive(32'd50_000_000, 24'd150_000, 1'b1, 1'b1, {32'd333, 24'd50_000}, 1'b1);
        drive(-32'd19_607_800, 24'd100_000, 1'b1, 1'b1, {32'hFFFF_FF3C, -24'd7_800}, 1'b1);
        drive(32'd7, -24'd2, 1'b1, 1'b1, {-32'd3, 24'd1}, 1'b1);
        drive(32'd12345, 24'd0, 1'b1, 1'b1, 56'd0, 1'b1);
        drive(32'h8000_0000, 24'hFF_FFFF, 1'b1, 1'b1, {32'h8000_0000, 24'd0}, 1'b1);
        drive(32'h8000_0000, 24'd1, 1'b1, 1'b1, {32'h8000_0000, 24'd0}, 1'b1);
        drive(32'h7FFF_FFFF, 24'h80_0000, 1'b1, 1'b1, {32'hFFFF_FF01, 24'h7F_FFFF}, 1'b1);
        drive(-32'd5, 24'd7, 1'b1, 1'b1, {32'd0, -24'd5}, 1'b1);
        // lone operand: nothing may be taken
        drive(32'd99, 24'd3, 1'b1, 1'b0, '0, 1'b0);
        drive(32'd99, 24'd3, 1'b0, 1'b1, '0, 1'b0);
        idle(40);

        // 40 back-to-back random pairs
        for (int i = 0; i < 40; i++) send_rand();
        idle(40);

        // burst with a one-cycle dividend gap
        for (int i = 0; i < 12; i++) begin
            if (i == 6) drive($urandom, 24'd9, 1'b0, 1'b1, '0, 1'b0);
            send_rand();
        end
        idle(40);

        // reset in the middle of a 20-pair burst
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                rst        = 1'b1;
                dvd_tvalid = 1'b0;
                dsr_tvalid = 1'b0;
                exp_q.delete();
                due_q.delete();
                #1;
                check("mid_rst_tvalid", 64'(dout_tvalid), 64'd0);
                check("mid_rst_tdata", 64'(dout_tdata), 64'd0);
                check("mid_rst_tready", 64'({dvd_tready, dsr_tready}), 64'd0);
                @(posedge aclk);
                #1;
                check("mid_rst_hold_tready", 64'({dvd_tready, dsr_tready}), 64'd0);
                rst = 1'b0;
                @(posedge aclk);
                #1;
                check("post_rst_tready", 64'({dvd_tready, dsr_tready}), 64'd3);
            end
            send_rand();
        end

        // drain, bounded
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
        check("drain", 64'(exp_q.size()), 64'd0);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
